// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants for the data-memory access controller: default sizes and
// the dump sequencer state encoding.
package dmem_ctrl_pkg;

  localparam int DEF_LEN        = 32;
  localparam int DEF_DUMP_WORDS = 2048;
  localparam int DEF_NB_PTR     = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HALT = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_HOLD      = 3'd4,
    ST_DONE      = 3'd5
  } dump_state_t;

  // The sequencer owns the RAM port from the first read until the done cycle.
  function automatic logic seq_owns_ram(input dump_state_t s);
    return !((s == ST_IDLE) || (s == ST_WAIT_HALT));
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Debug-side dump port: start request, status and the streamed word channel.
interface dmem_dump_if
  import dmem_ctrl_pkg::*;
#(
  parameter int LEN    = DEF_LEN,
  parameter int NB_PTR = DEF_NB_PTR
);

  logic              start;
  logic              busy;
  logic              done;
  logic [LEN-1:0]    checksum;
  // valid/ready: a word transfers on a rising edge where valid and ready are
  // both high; while valid is high and ready low, data and addr stay stable.
  logic              valid;
  logic              ready;
  logic [LEN-1:0]    data;
  logic [NB_PTR-1:0] addr;

  modport master (
    input  start, ready,
    output busy, done, checksum, valid, data, addr
  );

  modport slave (
    output start, ready,
    input  busy, done, checksum, valid, data, addr
  );

endinterface

// File: rtl/dmem_access_ctrl_dump_seq.sv
// Dump sequencer: FSM, word pointer, stream output registers and the optional
// running checksum (enabled by DMEM_DUMP_CHECKSUM_EN).
module dmem_dump_seq
  import dmem_ctrl_pkg::*;
#(
  parameter int LEN        = DEF_LEN,
  parameter int DUMP_WORDS = DEF_DUMP_WORDS,
  parameter int NB_PTR     = DEF_NB_PTR
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           pipe_halted,
  input  logic [LEN-1:0] ram_rdata,
  output logic           ram_req,
  output logic [LEN-1:0] ram_addr,
  output logic           owns_ram,
  output dump_state_t    state,
  dmem_dump_if.master    dump
);

  localparam logic [NB_PTR-1:0] LAST_PTR = NB_PTR'(DUMP_WORDS - 1);

  dump_state_t       state_q, state_d;
  logic [NB_PTR-1:0] ptr_q;
  logic [LEN-1:0]    data_q;
  logic [NB_PTR-1:0] addr_q;
  logic              valid_q;
  logic              accept;

  assign accept = (state_q == ST_HOLD) && valid_q && dump.ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (dump.start) state_d = ST_WAIT_HALT;
      ST_WAIT_HALT: if (pipe_halted) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_CAPTURE;
      ST_CAPTURE:   state_d = ST_HOLD;
      ST_HOLD:      if (accept) state_d = (ptr_q == LAST_PTR) ? ST_DONE : ST_ISSUE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // RAM data arrives in CAPTURE, one cycle after the read issued in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          data_q  <= ram_rdata;
          addr_q  <= ptr_q;
          valid_q <= 1'b1;
        end
        ST_HOLD: begin
          if (accept) begin
            valid_q <= 1'b0;
            if (ptr_q != LAST_PTR) ptr_q <= ptr_q + NB_PTR'(1);
          end
        end
        ST_DONE: ptr_q <= '0;
        default: ;
      endcase
    end
  end

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [LEN-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst)                                   sum_q <= '0;
    else if ((state_q == ST_IDLE) && dump.start) sum_q <= '0;
    else if (accept)                           sum_q <= sum_q + data_q;
  end

  assign dump.checksum = sum_q;
`else
  assign dump.checksum = '0;
`endif

  assign dump.busy  = (state_q != ST_IDLE);
  assign dump.done  = (state_q == ST_DONE);
  assign dump.valid = valid_q;
  assign dump.data  = data_q;
  assign dump.addr  = addr_q;

  assign ram_req  = (state_q == ST_ISSUE);
  assign ram_addr = LEN'(ptr_q);
  assign owns_ram = seq_owns_ram(state_q);
  assign state    = state_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory port arbiter between the MEM stage and the debug dump sequencer.
// Optional dump checksum: define DMEM_DUMP_CHECKSUM_EN.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int LEN        = DEF_LEN,
  parameter int DUMP_WORDS = DEF_DUMP_WORDS,
  parameter int NB_PTR     = DEF_NB_PTR
)(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [LEN-1:0] i_pipe_addr,
  input  logic [LEN-1:0] i_pipe_wdata,
  input  logic           i_pipe_en,
  input  logic           i_pipe_we,
  output logic           o_pipe_stall,
  input  logic           i_pipe_halted,
  dmem_dump_if.master    dump,
  output logic [LEN-1:0] o_ram_addr,
  output logic [LEN-1:0] o_ram_wdata,
  output logic           o_ram_en,
  output logic           o_ram_we,
  input  logic [LEN-1:0] i_ram_rdata,
  output logic [2:0]     o_dbg_state
);

  logic           seq_req;
  logic [LEN-1:0] seq_addr;
  logic           seq_owns;
  dump_state_t    seq_state;

  dmem_dump_seq #(
    .LEN        (LEN),
    .DUMP_WORDS (DUMP_WORDS),
    .NB_PTR     (NB_PTR)
  ) u_seq (
    .clk         (i_clk),
    .rst         (i_rst),
    .pipe_halted (i_pipe_halted),
    .ram_rdata   (i_ram_rdata),
    .ram_req     (seq_req),
    .ram_addr    (seq_addr),
    .owns_ram    (seq_owns),
    .state       (seq_state),
    .dump        (dump)
  );

  // While the sequencer owns the port, pipeline requests are refused, never forwarded.
  always_comb begin
    o_ram_addr   = i_pipe_addr;
    o_ram_wdata  = i_pipe_wdata;
    o_ram_en     = i_pipe_en;
    o_ram_we     = i_pipe_we;
    o_pipe_stall = 1'b0;
    if (seq_owns) begin
      o_ram_addr   = seq_addr;
      o_ram_wdata  = '0;
      o_ram_en     = seq_req;
      o_ram_we     = 1'b0;
      o_pipe_stall = i_pipe_en;
    end
  end

  assign o_dbg_state = seq_state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl with a behavioural RAM/dump model.
module tb_dmem_access_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int LEN = 32;
  localparam int DW  = 8;
  localparam int PW  = 3;
  localparam int EW  = PW + LEN;
  localparam int DUMP_LIMIT = 400;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [LEN-1:0] pipe_addr, pipe_wdata;
  logic           pipe_en, pipe_we, pipe_stall, pipe_halted;
  logic [LEN-1:0] ram_addr, ram_wdata, ram_rdata;
  logic           ram_en, ram_we;
  logic [2:0]     dbg_state;

  dmem_dump_if #(.LEN(LEN), .NB_PTR(PW)) dump_bus ();

  dmem_access_ctrl #(.LEN(LEN), .DUMP_WORDS(DW), .NB_PTR(PW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pipe_addr   (pipe_addr),
    .i_pipe_wdata  (pipe_wdata),
    .i_pipe_en     (pipe_en),
    .i_pipe_we     (pipe_we),
    .o_pipe_stall  (pipe_stall),
    .i_pipe_halted (pipe_halted),
    .dump          (dump_bus),
    .o_ram_addr    (ram_addr),
    .o_ram_wdata   (ram_wdata),
    .o_ram_en      (ram_en),
    .o_ram_we      (ram_we),
    .i_ram_rdata   (ram_rdata),
    .o_dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM instance: synchronous read, data one cycle after an enabled access
  logic [LEN-1:0] mem [DW];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[PW-1:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[PW-1:0]];
    end
  end

  // reference model and scoreboard
  logic [LEN-1:0] ref_mem [DW];
  logic [EW-1:0]  exp_q[$];
  logic [EW-1:0]  mon_e;
  logic [LEN-1:0] exp_sum;
  int n_checks = 0;
  int n_fail   = 0;
  int accepted = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dump_bus.valid && dump_bus.ready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 64'(dump_bus.addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_addr", 64'(dump_bus.addr), 64'(mon_e[EW-1:LEN]));
          check("beat_data", 64'(dump_bus.data), 64'(mon_e[LEN-1:0]));
        end
        accepted++;
      end
      if (dump_bus.done) done_cnt++;
    end
  end

  // driver tasks
  task automatic pipe_access(input bit we, input logic [LEN-1:0] a, input logic [LEN-1:0] wd);
    @(posedge clk); #1;
    pipe_en = 1'b1; pipe_we = we; pipe_addr = a; pipe_wdata = wd;
    #1;
    check("pt_addr",  64'(ram_addr),   64'(a));
    check("pt_wdata", 64'(ram_wdata),  64'(wd));
    check("pt_en",    64'(ram_en),     64'(1));
    check("pt_we",    64'(ram_we),     64'(we));
    check("pt_stall", 64'(pipe_stall), 64'(0));
    @(posedge clk); #1;
    pipe_en = 1'b0; pipe_we = 1'b0;
    if (we) ref_mem[a[PW-1:0]] = wd;
    else    check("pt_rdata", 64'(ram_rdata), 64'(ref_mem[a[PW-1:0]]));
  endtask

  task automatic run_dump(input int halt_delay, input int bp_word, input bit conflict, input int rst_word);
    int bp_cnt;
    int cyc;
    int done_before;
    bit finished;
    bit holding;
    logic [LEN-1:0] exp_cs;
    bp_cnt = 0; cyc = 0; finished = 1'b0;
    done_before = done_cnt;
    exp_q.delete();
    exp_sum  = '0;
    accepted = 0;
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back({PW'(i), ref_mem[i]});
      exp_sum = exp_sum + ref_mem[i];
    end
    @(posedge clk); #1;
    dump_bus.ready  = 1'b1;
    pipe_halted     = (halt_delay == 0);
    dump_bus.start  = 1'b1;
    @(posedge clk); #1;
    dump_bus.start = 1'b0;
    while (!finished && cyc < DUMP_LIMIT) begin
      pipe_en = 1'b0; pipe_we = 1'b0; dump_bus.ready = 1'b1; dump_bus.start = 1'b0;
      holding = 1'b0;
      if (dump_bus.done) begin
        finished = 1'b1;
      end else if (cyc < halt_delay) begin
        pipe_en = 1'b1; pipe_addr = $urandom_range(0, DW-1);
        #1;
        check("wait_busy",     64'(dump_bus.busy),  64'(1));
        check("wait_no_valid", 64'(dump_bus.valid), 64'(0));
        check("wait_pt_en",    64'(ram_en),         64'(1));
        check("wait_pt_addr",  64'(ram_addr),       64'(pipe_addr));
        check("wait_stall",    64'(pipe_stall),     64'(0));
      end else begin
        pipe_halted = (accepted < DW - 2);
        if (conflict && cyc > halt_delay) begin
          pipe_en = 1'b1; pipe_we = 1'b1;
          pipe_addr = $urandom_range(0, DW-1); pipe_wdata = $urandom;
          dump_bus.start = dump_bus.valid;
        end
        if (rst_word >= 0 && dump_bus.valid && int'(dump_bus.addr) == rst_word) begin
          dump_bus.ready = 1'b0; rst = 1'b1;
          @(posedge clk); #1;
          check("rst_valid",    64'(dump_bus.valid), 64'(0));
          check("rst_busy",     64'(dump_bus.busy),  64'(0));
          check("rst_done",     64'(dump_bus.done),  64'(0));
          check("rst_accepted", 64'(accepted),       64'(rst_word));
          rst = 1'b0; pipe_en = 1'b0; pipe_we = 1'b0; dump_bus.start = 1'b0;
          pipe_halted = 1'b0;
          exp_q.delete();
          return;
        end
        if (bp_word >= 0 && dump_bus.valid && int'(dump_bus.addr) == bp_word && bp_cnt < 5) begin
          dump_bus.ready = 1'b0; bp_cnt++; holding = 1'b1;
          check("bp_addr", 64'(dump_bus.addr), 64'(bp_word));
          check("bp_data", 64'(dump_bus.data), 64'(ref_mem[bp_word]));
        end
        #1;
        check("seq_ram_we", 64'(ram_we), 64'(0));
        if (conflict && cyc > halt_delay) check("conflict_stall", 64'(pipe_stall), 64'(1));
        if (ram_en) check("issue_addr", 64'(ram_addr), 64'(accepted));
        if (holding) check("bp_no_ram", 64'(ram_en), 64'(0));
      end
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("dump_done_seen", 64'(finished), 64'(1));
    if (bp_word >= 0) check("bp_cycles", 64'(bp_cnt), 64'(5));
    @(posedge clk); #1;
`ifdef DMEM_DUMP_CHECKSUM_EN
    exp_cs = exp_sum;
`else
    exp_cs = '0;
`endif
    check("done_once",  64'(done_cnt - done_before), 64'(1));
    check("idle_busy",  64'(dump_bus.busy),  64'(0));
    check("idle_done",  64'(dump_bus.done),  64'(0));
    check("idle_valid", 64'(dump_bus.valid), 64'(0));
    check("beats",      64'(accepted),       64'(DW));
    check("exp_empty",  64'(exp_q.size()),   64'(0));
    check("checksum",   64'(dump_bus.checksum), 64'(exp_cs));
    repeat (2) @(posedge clk);
    #1;
    check("checksum_hold", 64'(dump_bus.checksum), 64'(exp_cs));
    pipe_halted = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    pipe_addr = '0; pipe_wdata = '0; pipe_en = 1'b0; pipe_we = 1'b0; pipe_halted = 1'b0;
    dump_bus.start = 1'b0; dump_bus.ready = 1'b0;
    for (int i = 0; i < DW; i++) ref_mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid",    64'(dump_bus.valid),    64'(0));
    check("reset_busy",     64'(dump_bus.busy),     64'(0));
    check("reset_done",     64'(dump_bus.done),     64'(0));
    check("reset_data",     64'(dump_bus.data),     64'(0));
    check("reset_addr",     64'(dump_bus.addr),     64'(0));
    check("reset_checksum", 64'(dump_bus.checksum), 64'(0));
    check("reset_stall",    64'(pipe_stall),        64'(0));
    rst = 1'b0;

    pipe_access(1'b1, 32'd5, 32'hDEAD_BEEF);
    pipe_access(1'b0, 32'd5, 32'h0);

    for (int i = 0; i < DW; i++) pipe_access(1'b1, LEN'(i), LEN'(i * 3));
    run_dump(0, -1, 1'b0, -1);
    run_dump(0, 2, 1'b0, -1);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) pipe_access(1'b1, LEN'($urandom_range(0, DW-1)), LEN'($urandom));
      else                           pipe_access(1'b0, LEN'($urandom_range(0, DW-1)), '0);
    end
    run_dump(10, -1, 1'b1, -1);

    d0 = done_cnt;
    run_dump(0, -1, 1'b0, 3);
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_done", 64'(done_cnt - d0), 64'(0));
    check("post_rst_busy",    64'(dump_bus.busy),  64'(0));
    run_dump(0, $urandom_range(0, DW-1), 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
